// File: rtl/rv32_lsu_mem_stage.sv
// Memory-stage load/store unit: issues one data-bus access per load/store,
// stalls the pipeline until the response or a timeout, and formats load data.
module rv32_lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_load,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic        pipe_stop,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] result_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_we,
  output logic [3:0]  mem_req_wstrb,
  output logic [31:0] mem_req_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata,
  input  logic        mem_rsp_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;

  logic        op_bad;
  logic        op_accept;
  logic        timeout_hit;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;

  // Select and extend the addressed byte/halfword out of the read word
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> {off, 3'b000});
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return rd;
    endcase
  endfunction

  // Decode legality/alignment of the incoming op and build store byte lanes
  always_comb begin
    logic illegal;
    logic unaligned;
    illegal   = op_load ? (op_funct3 == 3'b011 || op_funct3 == 3'b110 || op_funct3 == 3'b111)
                        : (op_funct3 >= 3'b011);
    unaligned = (op_funct3[1:0] == 2'b01 && op_addr[0]) ||
                (op_funct3[1:0] == 2'b10 && op_addr[1:0] != 2'b00);
    op_bad    = illegal || unaligned;
    lane_strb  = 4'b0000;
    lane_wdata = 32'b0;
    if (!op_load) begin
      case (op_funct3[1:0])
        2'b00: begin
          lane_strb  = 4'b0001 << op_addr[1:0];
          lane_wdata = {4{op_wdata[7:0]}};
        end
        2'b01: begin
          lane_strb  = 4'b0011 << op_addr[1:0];
          lane_wdata = {2{op_wdata[15:0]}};
        end
        default: begin
          lane_strb  = 4'b1111;
          lane_wdata = op_wdata;
        end
      endcase
    end
  end

  assign op_accept   = (state_q == IDLE) && op_valid && !op_bad;
  assign timeout_hit = (cnt_q == CNT_LAST);

  // State and captured-access registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      off_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      off_q    <= off_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic; a response arriving outside WAIT is simply ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (op_accept) state_d = REQ;
      REQ:  if (mem_req_ready) state_d = WAIT;
      WAIT: if (mem_rsp_valid || timeout_hit) state_d = DONE;
      DONE: if (!pipe_stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the access on accept, run the timeout counter, latch the result
  always_comb begin
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    funct3_d = funct3_q;
    off_d    = off_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (op_accept) begin
          addr_d   = {op_addr[31:2], 2'b00};
          we_d     = !op_load;
          wstrb_d  = lane_strb;
          wdata_d  = lane_wdata;
          funct3_d = op_funct3;
          off_d    = op_addr[1:0];
          result_d = '0;
          err_d    = 1'b0;
        end
      end
      REQ: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rsp_valid) begin
          err_d    = mem_rsp_err;
          result_d = (we_q || mem_rsp_err) ? 32'b0 : fmt_load(funct3_q, off_q, mem_rsp_rdata);
        end else if (timeout_hit) begin
          err_d    = 1'b1;
          result_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Outputs, all forced low while reset is asserted
  always_comb begin
    stall         = !reset && (op_accept || state_q == REQ || state_q == WAIT);
    misalign      = !reset && (state_q == IDLE) && op_valid && op_bad;
    mem_req_valid = !reset && (state_q == REQ);
    mem_req_addr  = reset ? 32'b0 : addr_q;
    mem_req_we    = !reset && we_q;
    mem_req_wstrb = reset ? 4'b0 : wstrb_q;
    mem_req_wdata = reset ? 32'b0 : wdata_q;
    result_valid  = !reset && (state_q == DONE);
    result_data   = result_valid ? result_q : 32'b0;
    bus_err       = result_valid && err_q;
  end

endmodule

// File: tb/tb_rv32_lsu_mem_stage.sv
// Directed bench for rv32_lsu_mem_stage with scoreboard queues for
// requests and results checked by independent monitors.
module tb_rv32_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_load, pipe_stop;
  logic [2:0]  op_funct3;
  logic [31:0] op_addr, op_wdata;
  logic        stall, result_valid, misalign, bus_err;
  logic [31:0] result_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;

  typedef struct {logic [31:0] data; logic err;} res_t;
  typedef struct {logic [31:0] addr; logic we; logic [3:0] wstrb; logic [31:0] wdata;} req_t;

  res_t exp_res[$];
  req_t exp_req[$];
  int   checks = 0;
  int   passes = 0;
  logic prev_rv = 1'b0;

  rv32_lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_load(op_load), .op_funct3(op_funct3),
    .op_addr(op_addr), .op_wdata(op_wdata), .pipe_stop(pipe_stop),
    .stall(stall), .result_valid(result_valid), .result_data(result_data),
    .misalign(misalign), .bus_err(bus_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Result monitor: one pop per result (rising edge of result_valid)
  always @(negedge clk) begin
    if (!reset && result_valid && !prev_rv) begin
      if (exp_res.size() == 0) begin
        check_output("unexpected_result", 69'(result_data), 69'(0));
      end else begin
        res_t r;
        r = exp_res.pop_front();
        check_output("result_data", 69'(result_data), 69'(r.data));
        check_output("bus_err", 69'(bus_err), 69'(r.err));
      end
    end
    prev_rv = result_valid;
  end

  // Request monitor: compare fields whenever the handshake completes
  always @(negedge clk) begin
    if (!reset && mem_req_valid && mem_req_ready) begin
      if (exp_req.size() == 0) begin
        check_output("unexpected_req", 69'(mem_req_addr), 69'(0));
      end else begin
        req_t q;
        q = exp_req.pop_front();
        check_output("req_fields", {mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata},
                     {q.addr, q.we, q.wstrb, q.wdata});
      end
    end
  end

  // Drive one legal access and act as the bus slave until it retires
  task automatic apply_stimulus(input string name, input logic ld, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int ready_delay, input logic respond,
                                input logic [31:0] rdata, input logic rerr, input int ps_cycles,
                                input int exp_stall, input logic [31:0] exp_data, input logic exp_err,
                                input logic [31:0] exp_addr, input logic exp_we,
                                input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
    int stall_cnt = 0;
    int rv_cnt = 0;
    int wait_cnt = 0;
    int unstable = 0;
    logic pending = 1'b0;
    logic finished = 1'b0;
    exp_req.push_back('{exp_addr, exp_we, exp_wstrb, exp_wdata});
    exp_res.push_back('{exp_data, exp_err});
    op_valid = 1'b1; op_load = ld; op_funct3 = f3; op_addr = addr; op_wdata = wdata;
    for (int cyc = 0; cyc < 80 && !finished; cyc++) begin
      mem_rsp_valid = pending && respond;
      mem_rsp_rdata = rdata;
      mem_rsp_err   = rerr;
      pending = 1'b0;
      if (mem_req_valid) begin
        mem_req_ready = (wait_cnt >= ready_delay);
        wait_cnt++;
        if ({mem_req_addr, mem_req_we, mem_req_wstrb, mem_req_wdata} !==
            {exp_addr, exp_we, exp_wstrb, exp_wdata}) unstable++;
      end else begin
        mem_req_ready = 1'b0;
      end
      pipe_stop = 1'b0;
      if (result_valid) begin
        rv_cnt++;
        if (rv_cnt <= ps_cycles) pipe_stop = 1'b1;
        else begin
          op_valid = 1'b0;
          finished = 1'b1;
        end
      end
      #1;
      if (stall) stall_cnt++;
      if (mem_req_valid && mem_req_ready) pending = 1'b1;
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; pipe_stop = 1'b0; op_valid = 1'b0;
    if (!finished) begin
      $display("[TB] FAIL %s_budget: access did not retire within cycle budget", name);
      checks++;
    end
    check_output({name, "_stall_cycles"}, 69'(stall_cnt), 69'(exp_stall));
    check_output({name, "_req_stable"}, 69'(unstable), 69'(0));
    if (ps_cycles > 0) check_output({name, "_held_cycles"}, 69'(rv_cnt), 69'(ps_cycles + 1));
    check_output({name, "_back_idle"}, 69'({result_valid, stall}), 69'(0));
  endtask

  // Illegal or misaligned op: flagged, never stalls, never reaches the bus
  task automatic apply_bad(input string name, input logic ld, input logic [2:0] f3,
                           input logic [31:0] addr);
    int reqs = 0;
    op_valid = 1'b1; op_load = ld; op_funct3 = f3; op_addr = addr; op_wdata = 32'h5555_AAAA;
    #1;
    check_output({name, "_misalign"}, 69'(misalign), 69'(1));
    check_output({name, "_no_stall"}, 69'(stall), 69'(0));
    for (int i = 0; i < 3; i++) begin
      if (mem_req_valid) reqs++;
      @(posedge clk); #1;
      if (mem_req_valid) reqs++;
    end
    check_output({name, "_no_req"}, 69'(reqs), 69'(0));
    op_valid = 1'b0;
    #1;
    check_output({name, "_cleared"}, 69'(misalign), 69'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op_load = 1'b1; op_funct3 = 3'b010; op_addr = 32'h100;
    op_wdata = 32'h0; pipe_stop = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    mem_rsp_rdata = 32'h0; mem_rsp_err = 1'b0;
    #12;
    // Outputs must stay low under reset even with a legal and an illegal op presented
    op_valid = 1'b1;
    #1;
    check_output("reset_outputs", {stall, result_valid, mem_req_valid, misalign, bus_err, result_data},
                 69'(0));
    op_funct3 = 3'b011;
    #1;
    check_output("reset_misalign", 69'(misalign), 69'(0));
    op_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_output("idle_after_reset", {stall, result_valid, mem_req_valid}, 69'(0));

    apply_stimulus("lw", 1, 3'b010, 32'h100, 0, 0, 1, 32'hDEADBEEF, 0, 0, 3, 32'hDEADBEEF, 0,
                   32'h100, 0, 4'b0000, 32'h0);
    apply_stimulus("lb", 1, 3'b000, 32'h103, 0, 0, 1, 32'h80FF0000, 0, 0, 3, 32'hFFFFFF80, 0,
                   32'h100, 0, 4'b0000, 32'h0);
    apply_stimulus("lbu", 1, 3'b100, 32'h103, 0, 0, 1, 32'h80FF0000, 0, 0, 3, 32'h00000080, 0,
                   32'h100, 0, 4'b0000, 32'h0);
    apply_stimulus("lhu", 1, 3'b101, 32'h102, 0, 0, 1, 32'h80FF0000, 0, 0, 3, 32'h000080FF, 0,
                   32'h100, 0, 4'b0000, 32'h0);
    apply_stimulus("lh", 1, 3'b001, 32'h102, 0, 0, 1, 32'h80FF0000, 0, 0, 3, 32'hFFFF80FF, 0,
                   32'h100, 0, 4'b0000, 32'h0);
    apply_stimulus("lb_off1", 1, 3'b000, 32'h101, 0, 0, 1, 32'h80FF7F00, 0, 0, 3, 32'h0000007F, 0,
                   32'h100, 0, 4'b0000, 32'h0);
    // Store held off by the slave for 5 cycles: 1 IDLE + 6 REQ + 1 WAIT stall cycles
    apply_stimulus("sh", 0, 3'b001, 32'h202, 32'h1234ABCD, 5, 1, 32'hFFFFFFFF, 0, 0, 8, 32'h0, 0,
                   32'h200, 1, 4'b1100, 32'hABCDABCD);
    apply_stimulus("sb", 0, 3'b000, 32'h301, 32'h000000A5, 0, 1, 32'h0, 0, 0, 3, 32'h0, 0,
                   32'h300, 1, 4'b0010, 32'hA5A5A5A5);
    apply_stimulus("sw", 0, 3'b010, 32'h404, 32'hCAFEF00D, 0, 1, 32'h0, 0, 0, 3, 32'h0, 0,
                   32'h404, 1, 4'b1111, 32'hCAFEF00D);

    apply_bad("lw_mis", 1, 3'b010, 32'h101);
    apply_bad("ld_f3_011", 1, 3'b011, 32'h100);
    apply_bad("sh_mis", 0, 3'b001, 32'h203);
    apply_bad("st_f3_100", 0, 3'b100, 32'h100);

    // No response: 4 WAIT cycles then abort with bus_err
    apply_stimulus("timeout", 1, 3'b010, 32'h500, 0, 0, 0, 32'h0, 0, 0, 6, 32'h0, 1,
                   32'h500, 0, 4'b0000, 32'h0);
    apply_stimulus("rsp_err", 1, 3'b010, 32'h600, 0, 0, 1, 32'h12345678, 1, 0, 3, 32'h0, 1,
                   32'h600, 0, 4'b0000, 32'h0);
    // pipe_stop high for 3 DONE cycles keeps DONE for those plus the releasing cycle
    apply_stimulus("pipe_stop", 1, 3'b010, 32'h700, 0, 0, 1, 32'h0BADF00D, 0, 3, 3, 32'h0BADF00D, 0,
                   32'h700, 0, 4'b0000, 32'h0);

    // Reset while waiting for a response, then a late response that must be dropped
    exp_req.push_back('{32'h800, 1'b0, 4'b0000, 32'h0});
    op_valid = 1'b1; op_load = 1'b1; op_funct3 = 3'b010; op_addr = 32'h800;
    @(posedge clk); #1;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    check_output("rst_in_wait_stall", 69'({stall, mem_req_valid}), 69'(2'b10));
    #2;
    reset = 1'b1;
    #1;
    check_output("rst_drops_req", 69'({stall, mem_req_valid}), 69'(0));
    op_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'hBAD0BAD0; mem_rsp_err = 1'b0;
    #1;
    check_output("late_rsp_ignored", 69'({result_valid, stall}), 69'(0));
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    check_output("late_rsp_still_idle", 69'({result_valid, stall, mem_req_valid}), 69'(0));

    apply_stimulus("lw_after_rst", 1, 3'b010, 32'h900, 0, 0, 1, 32'h01020304, 0, 0, 3, 32'h01020304, 0,
                   32'h900, 0, 4'b0000, 32'h0);

    repeat (2) @(posedge clk);
    check_output("res_queue_empty", 69'(exp_res.size()), 69'(0));
    check_output("req_queue_empty", 69'(exp_req.size()), 69'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Absolute guard so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] global timeout");
  end

endmodule
